// File: rtl/icgtn_multi_pkg.sv
// icgtn_multi_pkg: shared types, state encoding and channel-count limits for the multi-channel clock gate.
// Contents:
//   chan_state_t : per-channel gate state {OFF, ON, DRAIN}
//   ACT_BIT      : state bit that directly drives the gate enable
//   NCH_MIN/MAX  : legal channel-count range, checked by nch_ok()
package icgtn_multi_pkg;

    // Bit 0 is the gate-open flag, so ACT comes straight off a flop and the
    // ON<->DRAIN transitions only toggle bit 1, never disturbing the enable.
    typedef enum logic [1:0] {
        OFF   = 2'b00,
        ON    = 2'b01,
        DRAIN = 2'b11
    } chan_state_t;

    localparam int ACT_BIT = 0;
    localparam int NCH_MIN = 1;
    localparam int NCH_MAX = 32;

    function automatic bit nch_ok(input int n);
        return (n >= NCH_MIN) && (n <= NCH_MAX);
    endfunction

endpackage

// File: rtl/icgtn_multi_chan.sv
// icgtn_multi_chan: one negative-phase clock-gate channel with idle hysteresis.
// Ports:
//   clkn     : shared clock, state updates on its rising edge
//   rn       : synchronous active-low reset
//   req      : effective request (test enable or unmasked functional enable)
//   hold     : idle cycles to keep the gate open, loaded on entry to DRAIN
//   act      : registered gate-open flag
//   act_next : gate-open flag the next edge will load
//   q        : gated clock, low pulses only while act is high
module icgtn_multi_chan
    import icgtn_multi_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic              clkn,
    input  logic              rn,
    input  logic              req,
    input  logic [HOLD_W-1:0] hold,
    output logic              act,
    output logic              act_next,
    output logic              q
);

    chan_state_t       state, state_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clkn) begin
        if (!rn) begin
            state <= OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Defaulting to OFF also pulls the unused encoding back to a legal state.
    always_comb begin
        state_nxt = OFF;
        cnt_nxt   = '0;
        if (req) begin
            state_nxt = ON;
        end else if (state == ON) begin
            state_nxt = (hold == '0) ? OFF : DRAIN;
            cnt_nxt   = hold;
        end else if (state == DRAIN) begin
            state_nxt = (cnt <= HOLD_W'(1)) ? OFF : DRAIN;
            cnt_nxt   = (cnt <= HOLD_W'(1)) ? '0 : cnt - HOLD_W'(1);
        end
    end

    always_comb begin
        act      = state[ACT_BIT];
        act_next = state_nxt[ACT_BIT];
    end

    // act only changes just after a rising edge, while clkn is high, so q
    // stays high across every open/close transition.
    assign q = clkn | ~act;

endmodule

// File: rtl/icgtn_multi.sv
// icgtn_multi: NCH negative-phase clock gates with per-channel hysteresis and a sleep handshake.
// Ports:
//   CLKN      : shared clock, all state updates on its rising edge
//   RN        : synchronous active-low reset
//   E         : per-channel functional enable
//   TE        : test enable, opens every gate and overrides sleep
//   HOLD      : idle cycles a gate stays open after its request drops
//   SLEEP_REQ : masks E so every channel drains and closes
//   SLEEP_ACK : registered, high while sleeping with every channel closed
//   ACT       : registered per-channel gate-open flags
//   Q         : gated clocks, Q[i] = CLKN | ~ACT[i]
module icgtn_multi
    import icgtn_multi_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int HOLD_W = 4
) (
    input  logic              CLKN,
    input  logic              RN,
    input  logic [NCH-1:0]    E,
    input  logic              TE,
    input  logic [HOLD_W-1:0] HOLD,
    input  logic              SLEEP_REQ,
    output logic              SLEEP_ACK,
    output logic [NCH-1:0]    ACT,
    output logic [NCH-1:0]    Q
);

    logic [NCH-1:0] req, act_next;

    if (!nch_ok(NCH)) begin : g_nch_bad
        $error("icgtn_multi: NCH out of range");
    end

    assign req = {NCH{TE}} | (E & {NCH{~SLEEP_REQ}});

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        icgtn_multi_chan #(.HOLD_W(HOLD_W)) u_chan (
            .clkn     (CLKN),
            .rn       (RN),
            .req      (req[c]),
            .hold     (HOLD),
            .act      (ACT[c]),
            .act_next (act_next[c]),
            .q        (Q[c])
        );
    end

    // Requiring both the present and the upcoming state to be closed makes the
    // ack rise one edge after the last channel closes, yet drop on the very
    // edge a test enable reopens the gates.
    always_ff @(posedge CLKN) begin
        if (!RN) SLEEP_ACK <= 1'b0;
        else     SLEEP_ACK <= SLEEP_REQ & ~|ACT & ~|act_next;
    end

endmodule

// File: tb/tb_icgtn_multi.sv
// tb_icgtn_multi: directed self-checking bench for icgtn_multi.
module tb_icgtn_multi;

    localparam int NCH    = 4;
    localparam int HOLD_W = 4;

    logic              CLKN = 1'b1;
    logic              RN = 1'b0;
    logic [NCH-1:0]    E = '0;
    logic              TE = 1'b0;
    logic [HOLD_W-1:0] HOLD = '0;
    logic              SLEEP_REQ = 1'b0;
    logic              SLEEP_ACK;
    logic [NCH-1:0]    ACT;
    logic [NCH-1:0]    Q;

    int tests = 0;
    int fails = 0;
    int pulses [NCH];
    int snap [NCH];

    icgtn_multi #(.NCH(NCH), .HOLD_W(HOLD_W)) dut (
        .CLKN      (CLKN),
        .RN        (RN),
        .E         (E),
        .TE        (TE),
        .HOLD      (HOLD),
        .SLEEP_REQ (SLEEP_REQ),
        .SLEEP_ACK (SLEEP_ACK),
        .ACT       (ACT),
        .Q         (Q)
    );

    always #5 CLKN = ~CLKN;

    initial for (int i = 0; i < NCH; i++) pulses[i] = 0;

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        always @(negedge Q[g]) pulses[g]++;
    end

    task automatic step;
        @(posedge CLKN);
        #1;
    endtask

    task automatic do_reset;
        RN = 1'b0; E = '0; TE = 1'b0; SLEEP_REQ = 1'b0; HOLD = '0;
        step;
        step;
        RN = 1'b1;
    endtask

    task automatic take_snap;
        for (int i = 0; i < NCH; i++) snap[i] = pulses[i];
    endtask

    task automatic test_reset;
        RN = 1'b0; E = 4'hF; TE = 1'b0; SLEEP_REQ = 1'b0; HOLD = '0;
        for (int k = 0; k < 3; k++) begin
            step;
            tests++;
            if (ACT !== 4'h0) begin fails++; $display("FAIL reset_act[%0d]: got %h want 0", k, ACT); end
            tests++;
            if (SLEEP_ACK !== 1'b0) begin fails++; $display("FAIL reset_ack[%0d]: got %b want 0", k, SLEEP_ACK); end
            #5;
            tests++;
            if (Q !== 4'hF) begin fails++; $display("FAIL reset_q[%0d]: got %h want f", k, Q); end
        end
        RN = 1'b1;
        step;
        tests++;
        if (ACT !== 4'hF) begin fails++; $display("FAIL reset_release_act: got %h want f", ACT); end
    endtask

    task automatic test_zero_hold;
        do_reset;
        HOLD = 4'd0;
        take_snap;
        E = 4'b0101;
        step;
        tests++;
        if (ACT !== 4'b0101) begin fails++; $display("FAIL zero_hold_open: got %h want 5", ACT); end
        repeat (4) step;
        E = 4'b0000;
        step;
        tests++;
        if (ACT !== 4'b0000) begin fails++; $display("FAIL zero_hold_close: got %h want 0", ACT); end
        repeat (3) step;
        for (int i = 0; i < NCH; i++) begin
            tests++;
            if (pulses[i] - snap[i] !== ((i % 2 == 0) ? 5 : 0)) begin
                fails++;
                $display("FAIL zero_hold_pulses[%0d]: got %0d want %0d", i, pulses[i] - snap[i], (i % 2 == 0) ? 5 : 0);
            end
        end
    endtask

    task automatic test_hysteresis;
        logic [3:0] ev;
        ev = 4'b1100;
        do_reset;
        HOLD = 4'd3;
        E = 4'b0001;
        step;
        for (int k = 0; k < 4; k++) begin
            E = {3'b000, ev[k]};
            step;
            tests++;
            if (ACT[0] !== 1'b1) begin fails++; $display("FAIL hyst_reentry[%0d]: got %b want 1", k, ACT[0]); end
        end
        E = 4'b0000;
        step;
        take_snap;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (ACT[0] !== 1'b1) begin fails++; $display("FAIL hyst_drain[%0d]: got %b want 1", k, ACT[0]); end
            if (k < 2) step;
        end
        step;
        tests++;
        if (ACT[0] !== 1'b0) begin fails++; $display("FAIL hyst_close: got %b want 0", ACT[0]); end
        tests++;
        if (pulses[0] - snap[0] !== 3) begin fails++; $display("FAIL hyst_pulses: got %0d want 3", pulses[0] - snap[0]); end
    endtask

    task automatic test_reentry_at_expiry;
        do_reset;
        HOLD = 4'd2;
        E = 4'b0001;
        step;
        E = 4'b0000;
        step;
        step;
        E = 4'b0001;
        step;
        tests++;
        if (ACT[0] !== 1'b1) begin fails++; $display("FAIL expiry_reentry: got %b want 1", ACT[0]); end
        E = 4'b0000;
        step;
        step;
        tests++;
        if (ACT[0] !== 1'b1) begin fails++; $display("FAIL expiry_restart: got %b want 1", ACT[0]); end
    endtask

    task automatic test_sleep_and_override;
        do_reset;
        HOLD = 4'd2;
        E = 4'hF;
        step;
        SLEEP_REQ = 1'b1;
        step;
        tests++;
        if (ACT !== 4'hF) begin fails++; $display("FAIL sleep_drain0: got %h want f", ACT); end
        step;
        tests++;
        if (ACT !== 4'hF) begin fails++; $display("FAIL sleep_drain1: got %h want f", ACT); end
        step;
        tests++;
        if (ACT !== 4'h0) begin fails++; $display("FAIL sleep_closed: got %h want 0", ACT); end
        tests++;
        if (SLEEP_ACK !== 1'b0) begin fails++; $display("FAIL sleep_ack_early: got %b want 0", SLEEP_ACK); end
        step;
        tests++;
        if (SLEEP_ACK !== 1'b1) begin fails++; $display("FAIL sleep_ack: got %b want 1", SLEEP_ACK); end
        TE = 1'b1;
        step;
        tests++;
        if (ACT !== 4'hF) begin fails++; $display("FAIL te_open: got %h want f", ACT); end
        tests++;
        if (SLEEP_ACK !== 1'b0) begin fails++; $display("FAIL te_ack_drop: got %b want 0", SLEEP_ACK); end
        step;
        TE = 1'b0;
        step;
        step;
        tests++;
        if (ACT !== 4'hF) begin fails++; $display("FAIL te_drain: got %h want f", ACT); end
        step;
        tests++;
        if (ACT !== 4'h0) begin fails++; $display("FAIL te_closed: got %h want 0", ACT); end
        tests++;
        if (SLEEP_ACK !== 1'b0) begin fails++; $display("FAIL te_ack_early: got %b want 0", SLEEP_ACK); end
        step;
        tests++;
        if (SLEEP_ACK !== 1'b1) begin fails++; $display("FAIL te_ack_back: got %b want 1", SLEEP_ACK); end
        SLEEP_REQ = 1'b0;
        step;
        tests++;
        if (SLEEP_ACK !== 1'b0) begin fails++; $display("FAIL wake_ack: got %b want 0", SLEEP_ACK); end
        tests++;
        if (ACT !== 4'hF) begin fails++; $display("FAIL wake_act: got %h want f", ACT); end
    endtask

    task automatic test_te_with_sleep;
        do_reset;
        TE = 1'b1;
        SLEEP_REQ = 1'b1;
        step;
        tests++;
        if (ACT !== 4'hF) begin fails++; $display("FAIL te_sleep_open: got %h want f", ACT); end
        tests++;
        if (SLEEP_ACK !== 1'b0) begin fails++; $display("FAIL te_sleep_ack: got %b want 0", SLEEP_ACK); end
        TE = 1'b0;
        HOLD = 4'd0;
        step;
        tests++;
        if (ACT !== 4'h0) begin fails++; $display("FAIL te_sleep_close: got %h want 0", ACT); end
        step;
        tests++;
        if (SLEEP_ACK !== 1'b1) begin fails++; $display("FAIL te_sleep_ack_set: got %b want 1", SLEEP_ACK); end
    endtask

    task automatic test_reset_mid_drain;
        do_reset;
        HOLD = 4'd15;
        E = 4'b0001;
        step;
        E = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step;
            tests++;
            if (ACT[0] !== 1'b1) begin fails++; $display("FAIL rdrain_open[%0d]: got %b want 1", k, ACT[0]); end
        end
        RN = 1'b0;
        step;
        tests++;
        if (ACT !== 4'h0) begin fails++; $display("FAIL rdrain_reset: got %h want 0", ACT); end
        take_snap;
        RN = 1'b1;
        step;
        step;
        tests++;
        if (pulses[0] !== snap[0]) begin fails++; $display("FAIL rdrain_no_pulse: got %0d want %0d", pulses[0], snap[0]); end
        E = 4'b0001;
        step;
        E = 4'b0000;
        for (int k = 0; k < 15; k++) begin
            step;
            tests++;
            if (ACT[0] !== 1'b1) begin fails++; $display("FAIL rdrain_recount[%0d]: got %b want 1", k, ACT[0]); end
        end
        step;
        tests++;
        if (ACT[0] !== 1'b0) begin fails++; $display("FAIL rdrain_recount_close: got %b want 0", ACT[0]); end
    endtask

    initial begin
        test_reset;
        test_zero_hold;
        test_hysteresis;
        test_reentry_at_expiry;
        test_sleep_and_override;
        test_te_with_sleep;
        test_reset_mid_drain;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icgtn_multi.md
# icgtn_multi

Parametrised multi-channel negative-phase integrated clock gate with per-channel idle hysteresis and a sleep handshake. Each channel passes low pulses of the shared clock `CLKN` while enabled and holds its output high while gated. The gate closes only after a programmable number of idle cycles, and a global sleep request drains all channels and acknowledges once every channel is closed. It sits between the power-management controller and the leaf clock trees of up to `NCH` subsystems.

## Interface
- `NCH`, 4: number of gated channels (1..32)
- `HOLD_W`, 4: width of the hysteresis counter and of `HOLD`
- `CLKN` in 1: clock. Low-phase-active (pulse low = active edge pair). All state updates on the rising edge of `CLKN`.
- `RN` in 1: reset, synchronous and active-low, sampled on rising `CLKN`
- `E` in `NCH`: per-channel functional enable
- `TE` in 1: global test enable; opens all gates and overrides sleep and hysteresis
- `HOLD` in `HOLD_W`: idle cycles a gate stays open after its enable drops. Sampled when a channel enters DRAIN.
- `SLEEP_REQ` in 1: request that all channels close and stay closed
- `SLEEP_ACK` out 1: registered; high while `SLEEP_REQ`=1 and every channel is OFF
- `ACT` out `NCH`: registered gate state per channel (1 = open)
- `Q` out `NCH`: gated clocks, `Q[i] = CLKN | ~ACT[i]`

## Operation
- Reset values (`RN`=0 at a rising edge): all channels OFF, `ACT`=0, counters 0, `SLEEP_ACK`=0, `Q` all high.
- Per-channel effective request: `req[i] = TE | (E[i] & ~SLEEP_REQ)`.
- Per-channel FSM, evaluated at each rising `CLKN` edge:
  - **OFF** (`ACT`=0). If `req` → ON.
  - **ON** (`ACT`=1). If `req` → stay ON. If `~req` and `HOLD`=0 → OFF. If `~req` and `HOLD`≠0 → DRAIN, with `cnt`=`HOLD`.
  - **DRAIN** (`ACT`=1). If `req` → ON; `cnt` is discarded. Otherwise, if `cnt`=1 → OFF; else `cnt`-1.
- Sleep behaviour:
  - `SLEEP_REQ` does not truncate DRAIN; hysteresis completes normally.
  - Deasserting `SLEEP_REQ` lets `E` take effect at the next edge.
- `TE`=1 behaviour:
  - Every channel is forced to ON at the next edge, regardless of state or `SLEEP_REQ`.
  - When `TE` falls, channels follow the normal ON exit path using the current `HOLD`.
- `SLEEP_ACK` is registered:
  - Set at the edge following a cycle in which `SLEEP_REQ`=1 and all next-states are OFF.
  - Cleared at the edge following `SLEEP_REQ`=0 or any channel leaving OFF, e.g. due to `TE`.
- `HOLD` changes during DRAIN do not affect a running count.
- `cnt` is `HOLD_W` bits wide and never wraps: the FSM leaves DRAIN at 1 and never decrements 0.

## Timing
- `E` sampled at rising edge n sets `ACT` at edge n. `Q[i]` first goes low in the low phase that follows edge n; enable-to-first-pulse latency is 1 edge.
- Closing latency from `E` dropping (sampled at edge n):
  - `HOLD`=0: `ACT`=0 at edge n; no further pulses.
  - `HOLD`=h: exactly h further low pulses, then `ACT`=0 at edge n+h.
- `ACT` changes only on rising `CLKN`, while `CLKN` is high. `Q` is therefore glitch-free: it is held high through every transition.
- Reset mid-DRAIN or mid-ON closes the gate at that edge. No partial pulse is produced.
- Simultaneous events:
  - `TE` rising together with `SLEEP_REQ` rising: ON wins.
  - `E` reasserted on the same edge DRAIN would expire (`cnt`=1): ON wins.
- Sleep-acknowledge latency: `SLEEP_ACK` rises 1 edge after the last channel reaches OFF.

## Structure
- Package `icgtn_multi_pkg`: channel state enum `{OFF, ON, DRAIN}`, state encoding constants, and an `NCH` range check.
- One sub-module, `icgtn_multi_chan`: a single-channel FSM plus counter plus gated-clock OR.
- The top level instantiates `NCH` copies of it and computes the `SLEEP_ACK` reduction register.

## Test plan
- **Reset:** hold `RN`=0 for 3 edges with `E`=all ones → `ACT`=0 and `Q`=all ones throughout. After release, `ACT`=all ones at the next edge.
- **Zero hysteresis:** `NCH`=4, `HOLD`=0, `E`=0b0101 for 5 edges, then 0 → `Q[0]` and `Q[2]` give exactly 5 low pulses; `Q[1]` and `Q[3]` never go low.
- **Hysteresis with re-entry:** `HOLD`=3, drop `E[0]` at edge 10, reassert at edge 12 → `ACT[0]` stays 1 continuously. Dropping it again at edge 20 gives `ACT[0]`=0 at edge 23, after exactly 3 pulses.
- **Sleep handshake:** `HOLD`=2, `E`=0b1111, assert `SLEEP_REQ` at edge 5 → all `ACT`=0 at edge 7 and `SLEEP_ACK`=1 at edge 8. Deasserting `SLEEP_REQ` clears `SLEEP_ACK` at the next edge.
- **Test override during sleep:** with `SLEEP_ACK`=1, pulse `TE` for 2 edges → all `ACT`=1 and `SLEEP_ACK`=0 at the next edge. After `TE` falls with `HOLD`=2: `ACT`=0 two edges later and `SLEEP_ACK`=1 one edge after that.
- **Reset mid-drain:** `HOLD`=15, drop `E` and assert `RN`=0 four edges later → `ACT`=0 at that edge, no pulse after it, and the counter restarts from `HOLD` on the next drain.
